// File: rtl/rsu_csd_pipe_if.sv
// ---------------------------------------------------------------------------
// rsu_csd_pipe_if
// Sample stream bundle for rsu_csd_pipe: an upstream valid/ready channel
// carrying input samples, and a downstream valid/ready channel carrying the
// scaled result with its per-sample saturation flag.
//
//   in_valid / in_ready / in_sample      upstream handshake + signed sample
//   out_valid / out_ready / out_sample   downstream handshake + signed result
//   out_sat                              result was clamped (qualified by out_valid)
//
// Modports:
//   master : the side that produces input samples and consumes results
//   slave  : the scaler itself
// ---------------------------------------------------------------------------
interface rsu_csd_pipe_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_sample;
  logic                     out_sat;

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_sample, out_sat
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_sample, out_sat
  );
endinterface

// File: rtl/rsu_csd_pipe.sv
// ---------------------------------------------------------------------------
// rsu_csd_pipe
// Radius scale-up: multiplies each signed input sample by a runtime constant
// written as a sum of up to NUM_TERMS signed power-of-two terms
// (e.g. 7 = 2^3 - 2^0). Three-stage shift-add pipeline with valid/ready flow
// control, optional fixed-point right scaling and output saturation.
//
//   Stage 1 : per-term +/-(sample <<< shift), or 0 when the term is disabled
//   Stage 2 : two partial sums (lower half of the terms, upper half)
//   Stage 3 : add, (optional round), arithmetic >>> FRAC_SHIFT, clamp to OUT_W
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   bus          rsu_csd_pipe_if.slave sample stream (in_* / out_*)
//   sat_sticky   set by any saturated output, held until sat_clr
//   sat_clr      clears sat_sticky (a same-cycle set wins)
//   cfg_we       write one shadow term {cfg_en, cfg_neg, cfg_shift} at cfg_idx
//   cfg_commit   copy the shadow bank to the active bank
//
// Build option:
//   RSU_ROUND_EN  when defined, stage 3 adds 2^(FRAC_SHIFT-1) before the
//                 right shift (round half up). No effect when FRAC_SHIFT = 0.
// ---------------------------------------------------------------------------
module rsu_csd_pipe #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 16,
  parameter int NUM_TERMS  = 4,
  parameter int SHIFT_W    = 3,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  rsu_csd_pipe_if.slave                bus,
  output logic                         sat_sticky,
  input  logic                         sat_clr,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TERMS)-1:0] cfg_idx,
  input  logic                         cfg_en,
  input  logic                         cfg_neg,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic                         cfg_commit
);

  localparam int IDX_W = $clog2(NUM_TERMS);
  // Wide enough for the largest shifted sample summed over every term.
  localparam int ACC_W = DATA_W + (1 << SHIFT_W) + IDX_W;
  localparam int HALF  = NUM_TERMS / 2;

  // Clamp limits expressed in the accumulator width; min is ~max in two's complement.
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

`ifdef RSU_ROUND_EN
  // Half an output LSB; evaluates to 0 when FRAC_SHIFT = 0.
  localparam logic signed [ACC_W-1:0] ROUND_ADD = (ACC_W'(1) << FRAC_SHIFT) >> 1;
`endif

  typedef struct packed {
    logic               en;
    logic               neg;
    logic [SHIFT_W-1:0] shift;
  } term_t;

  localparam term_t TERM_ONE = '{en: 1'b1, neg: 1'b0, shift: '0};
  localparam term_t TERM_OFF = '{en: 1'b0, neg: 1'b0, shift: '0};

  term_t shadow_q [NUM_TERMS];
  term_t active_q [NUM_TERMS];

  // Pipeline state
  logic                     v1_q, v2_q, out_valid_q;
  logic signed [ACC_W-1:0]  term_q [NUM_TERMS];
  logic signed [ACC_W-1:0]  p0_q, p1_q;
  logic signed [OUT_W-1:0]  out_sample_q;
  logic                     out_sat_q;
  logic                     sat_sticky_q;

  // Combinational next-stage values
  logic                     advance;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  term_c [NUM_TERMS];
  logic signed [ACC_W-1:0]  p0_c, p1_c;
  logic signed [ACC_W-1:0]  sum_c, scaled_c;
  logic signed [OUT_W-1:0]  res_c;
  logic                     res_sat_c;

  // The whole pipeline moves as one: it stalls only when a result is waiting
  // and downstream refuses it.
  assign advance = !out_valid_q || bus.out_ready;
  assign in_ext  = ACC_W'(bus.in_sample);

  // -------------------------------------------------------------------------
  // Term banks. Shadow is written one term at a time; commit copies the whole
  // bank. Both updates are non-blocking, so a commit in the same cycle as a
  // write copies the shadow contents from before that write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TERMS; i++) begin
        shadow_q[i] <= (i == 0) ? TERM_ONE : TERM_OFF;
        active_q[i] <= (i == 0) ? TERM_ONE : TERM_OFF;
      end
    end else begin
      if (cfg_commit) begin
        active_q <= shadow_q;
      end
      if (cfg_we && (int'(cfg_idx) < NUM_TERMS)) begin
        shadow_q[cfg_idx] <= '{en: cfg_en, neg: cfg_neg, shift: cfg_shift};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1 / stage 2 combinational logic
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_TERMS; i++) begin
      // NOTE: every always_comb output gets a default before any condition,
      // so no path leaves it unassigned and no latch is inferred.
      term_c[i] = '0;
      if (active_q[i].en) begin
        term_c[i] = active_q[i].neg ? -(in_ext <<< active_q[i].shift)
                                    :  (in_ext <<< active_q[i].shift);
      end
    end
  end

  always_comb begin
    p0_c = '0;
    p1_c = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (i < HALF) p0_c = p0_c + term_q[i];
      else          p1_c = p1_c + term_q[i];
    end
  end

  // -------------------------------------------------------------------------
  // Stage 3: final add, optional rounding, scaling, saturation
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here build the value step by step inside one
    // combinational evaluation; registers elsewhere use non-blocking only.
    sum_c = p0_q + p1_q;
`ifdef RSU_ROUND_EN
    sum_c = sum_c + ROUND_ADD;
`endif
    scaled_c  = sum_c >>> FRAC_SHIFT;
    res_c     = scaled_c[OUT_W-1:0];
    res_sat_c = 1'b0;
    if (scaled_c > SAT_MAX) begin
      res_c     = SAT_MAX[OUT_W-1:0];
      res_sat_c = 1'b1;
    end else if (scaled_c < SAT_MIN) begin
      res_c     = SAT_MIN[OUT_W-1:0];
      res_sat_c = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_sat_q    <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      if (advance) begin
        v1_q        <= bus.in_valid;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        if (v2_q) begin
          out_sample_q <= res_c;
          out_sat_q    <= res_sat_c;
        end
      end
      // Set has priority over clear.
      if (advance && v2_q && res_sat_c) sat_sticky_q <= 1'b1;
      else if (sat_clr)                 sat_sticky_q <= 1'b0;
    end
  end

  // NOTE: intermediate datapath registers carry no reset; the valid bits
  // above decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (advance) begin
      term_q <= term_c;
      p0_q   <= p0_c;
      p1_q   <= p1_c;
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_sample_q;
  assign bus.out_sat    = out_sat_q;
  assign sat_sticky     = sat_sticky_q;

endmodule

// File: tb/tb_rsu_csd_pipe.sv
// ---------------------------------------------------------------------------
// tb_rsu_csd_pipe
// Self-checking bench for rsu_csd_pipe. The reference model keeps the term
// banks as plain integers, forms the scale factor arithmetically, and holds
// expected results in a FIFO in acceptance order. A second instance with
// FRAC_SHIFT = 2 covers fixed-point scaling and the RSU_ROUND_EN build.
// ---------------------------------------------------------------------------
module tb_rsu_csd_pipe;
  localparam int DATA_W    = 16;
  localparam int OUT_W     = 16;
  localparam int NUM_TERMS = 4;
  localparam int SHIFT_W   = 3;
  localparam int IDX_W     = $clog2(NUM_TERMS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               sat_sticky, sat_sticky2, sat_clr;
  logic               cfg_we, cfg_en, cfg_neg, cfg_commit;
  logic [IDX_W-1:0]   cfg_idx;
  logic [SHIFT_W-1:0] cfg_shift;

  rsu_csd_pipe_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();
  rsu_csd_pipe_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus2 ();

  rsu_csd_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_TERMS(NUM_TERMS),
                 .SHIFT_W(SHIFT_W), .FRAC_SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .sat_sticky(sat_sticky), .sat_clr(sat_clr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_neg(cfg_neg),
    .cfg_shift(cfg_shift), .cfg_commit(cfg_commit));

  rsu_csd_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_TERMS(NUM_TERMS),
                 .SHIFT_W(SHIFT_W), .FRAC_SHIFT(2)) u_frac (
    .clk(clk), .rst(rst), .bus(bus2), .sat_sticky(sat_sticky2), .sat_clr(sat_clr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_neg(cfg_neg),
    .cfg_shift(cfg_shift), .cfg_commit(cfg_commit));

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct { bit en; bit neg; int shift; } mterm_t;
  mterm_t sh_m [NUM_TERMS];
  mterm_t ac_m [NUM_TERMS];
  longint exp_d[$];
  bit     exp_s[$];

  function automatic void model_reset();
    for (int i = 0; i < NUM_TERMS; i++) begin
      sh_m[i] = '{en: (i == 0), neg: 1'b0, shift: 0};
      ac_m[i] = '{en: (i == 0), neg: 1'b0, shift: 0};
    end
    exp_d.delete();
    exp_s.delete();
  endfunction

  function automatic longint factor_now();
    longint f = 0;
    for (int i = 0; i < NUM_TERMS; i++)
      if (ac_m[i].en) f += (ac_m[i].neg ? -1 : 1) * (longint'(1) << ac_m[i].shift);
    return f;
  endfunction

  // y = clamp(floor((x*f [+ d/2]) / d)), d = 2^fs
  function automatic void ref_out(input longint x, input longint f, input int fs,
                                  output longint y, output bit s);
    longint v, d, mx, mn;
    v  = x * f;
    d  = longint'(1) << fs;
`ifdef RSU_ROUND_EN
    if (fs > 0) v = v + d / 2;
`endif
    y = v / d;
    if ((v % d != 0) && (v < 0)) y = y - 1;
    mx = (longint'(1) << (OUT_W - 1)) - 1;
    mn = -(longint'(1) << (OUT_W - 1));
    s  = 1'b0;
    if (y > mx)      begin y = mx; s = 1'b1; end
    else if (y < mn) begin y = mn; s = 1'b1; end
  endfunction

  // ---------------- one clock of stimulus/observation ----------------
  bit     t_of, t_if, t_have, t_os, t_es, t_rdy, t_ov;
  longint t_od, t_ed;

  task automatic tick();
    longint y;
    bit     s;
    @(negedge clk);
    t_rdy = bus.in_ready;  t_ov = bus.out_valid;
    t_od  = bus.out_sample; t_os = bus.out_sat;
    t_of = 0; t_if = 0; t_have = 0; t_ed = 0; t_es = 0;
    if (rst) begin
      model_reset();
    end else begin
      t_of = bus.out_valid && bus.out_ready;
      t_if = bus.in_valid && bus.in_ready;
      if (t_of && exp_d.size() > 0) begin
        t_ed = exp_d.pop_front(); t_es = exp_s.pop_front(); t_have = 1;
      end
      if (t_if) begin
        ref_out(bus.in_sample, factor_now(), 0, y, s);
        exp_d.push_back(y); exp_s.push_back(s);
      end
      if (cfg_commit) ac_m = sh_m;
      if (cfg_we && cfg_idx < NUM_TERMS)
        sh_m[cfg_idx] = '{en: cfg_en, neg: cfg_neg, shift: int'(cfg_shift)};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input bit en, input bit neg, input int sh);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_en = en; cfg_neg = neg; cfg_shift = SHIFT_W'(sh);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
  endtask

  // Stream driver: pushes xs back-to-back, drops out_ready in [st_from, st_from+st_len),
  // pulses cfg_commit on cycle commit_cyc, and records what came out.
  longint g_d[$], g_ed[$], c_od[$];
  bit     g_s[$], g_es[$], g_h[$], c_rdy[$], c_ov[$];
  int     g_t[$];

  task automatic pump(input longint xs[$], input int st_from, input int st_len, input int commit_cyc);
    int idx = 0;
    int cyc = 0;
    g_d.delete(); g_ed.delete(); g_s.delete(); g_es.delete(); g_h.delete(); g_t.delete();
    c_od.delete(); c_rdy.delete(); c_ov.delete();
    while ((idx < xs.size() || g_d.size() < xs.size()) && cyc < 300) begin
      bus.in_valid  = (idx < xs.size());
      bus.in_sample = (idx < xs.size()) ? DATA_W'(xs[idx]) : '0;
      bus.out_ready = !(cyc >= st_from && cyc < st_from + st_len);
      cfg_commit    = (cyc == commit_cyc);
      tick();
      cfg_commit = 1'b0;
      if (t_if) idx++;
      c_rdy.push_back(t_rdy); c_ov.push_back(t_ov); c_od.push_back(t_od);
      if (t_of) begin
        g_d.push_back(t_od); g_s.push_back(t_os); g_ed.push_back(t_ed);
        g_es.push_back(t_es); g_h.push_back(t_have); g_t.push_back(cyc);
      end
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    longint xs[$];
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_sample !== '0) begin bad++; $display("FAIL reset_out_sample got=%0d want=0", bus.out_sample); end
    total++; if (bus.out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", bus.out_sat); end
    total++; if (sat_sticky !== 1'b0 || sat_sticky2 !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b/%b want=0", sat_sticky, sat_sticky2); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    xs.push_back(1234);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0]) begin bad++; $display("FAIL reset_factor1 got_n=%0d want_n=1", g_d.size()); end
  endtask

  task automatic test_basic();
    longint xs[$];
    do_reset();
    cfg_write(1, 1, 0, 1); cfg_write(2, 1, 0, 3); cfg_write(0, 0, 0, 0); commit();
    xs.push_back(100);
    pump(xs, 1000, 0, -1);
    total++;
    if (g_d.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", g_d.size()); end
    else begin
      if (!g_h[0] || g_d[0] !== g_ed[0] || g_s[0] !== g_es[0]) begin
        bad++; $display("FAIL basic_value got=%0d/%b want=%0d/%b", g_d[0], g_s[0], g_ed[0], g_es[0]);
      end
      total++; if (g_t[0] != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", g_t[0]); end
    end
  endtask

  task automatic test_back_to_back();
    longint xs[$];
    do_reset();
    cfg_write(0, 1, 0, 3); cfg_write(1, 1, 1, 0); commit();
    xs.push_back(-5);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0]) begin bad++; $display("FAIL f7_neg got_n=%0d want_n=1", g_d.size()); end
    xs.delete();
    for (int k = 1; k <= 8; k++) xs.push_back(k);
    pump(xs, 1000, 0, -1);
    total++;
    if (g_d.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", g_d.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (!g_h[i] || g_d[i] !== g_ed[i]) begin bad++; $display("FAIL b2b_value[%0d] got=%0d want=%0d", i, g_d[i], g_ed[i]); end
      end
      total++; if (g_t[7] - g_t[0] != 7) begin bad++; $display("FAIL b2b_spacing got=%0d want=7", g_t[7] - g_t[0]); end
    end
  endtask

  task automatic test_saturation();
    longint xs[$];
    do_reset();
    cfg_write(0, 1, 0, 7); commit();
    xs.push_back(1000);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0] || g_s[0] !== g_es[0]) begin bad++; $display("FAIL sat_pos got_n=%0d want_n=1", g_d.size()); end
    total++; if (sat_sticky !== 1'b1) begin bad++; $display("FAIL sat_sticky_set got=%b want=1", sat_sticky); end
    xs.delete(); xs.push_back(-1000);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0] || g_s[0] !== g_es[0]) begin bad++; $display("FAIL sat_neg got_n=%0d want_n=1", g_d.size()); end
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    total++; if (sat_sticky !== 1'b0) begin bad++; $display("FAIL sat_clr got=%b want=0", sat_sticky); end
    bus.in_valid = 1'b1; bus.in_sample = 16'sd1000; tick();
    bus.in_valid = 1'b0; tick();
    total++; if (sat_sticky !== 1'b0) begin bad++; $display("FAIL sat_early got=%b want=0", sat_sticky); end
    sat_clr = 1'b1; tick(); sat_clr = 1'b0;
    total++; if (sat_sticky !== 1'b1 || bus.out_sat !== 1'b1) begin bad++; $display("FAIL sat_set_wins got=%b/%b want=1/1", sat_sticky, bus.out_sat); end
    tick(); tick();
  endtask

  task automatic test_stall();
    longint xs[$];
    do_reset();
    for (int k = 1; k <= 6; k++) xs.push_back(k);
    pump(xs, 3, 4, -1);
    total++;
    if (g_d.size() != 6) begin bad++; $display("FAIL stall_count got=%0d want=6", g_d.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (!g_h[i] || g_d[i] !== g_ed[i]) begin bad++; $display("FAIL stall_value[%0d] got=%0d want=%0d", i, g_d[i], g_ed[i]); end
      end
    end
    for (int c = 3; c < 7 && c < c_ov.size(); c++) begin
      if (c_ov[c]) begin
        total++; if (c_rdy[c] !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d] got=%b want=0", c, c_rdy[c]); end
        total++; if (c_od[c] !== c_od[3]) begin bad++; $display("FAIL stall_hold[%0d] got=%0d want=%0d", c, c_od[c], c_od[3]); end
      end
    end
    begin
      int extra = 0;
      for (int c = 0; c < 5; c++) begin tick(); if (t_of) extra++; end
      total++; if (extra != 0) begin bad++; $display("FAIL stall_dup got=%0d want=0", extra); end
    end
  endtask

  task automatic test_commit();
    longint xs[$];
    int fired = 0;
    do_reset();
    cfg_write(0, 1, 0, 1);
    xs.push_back(10); xs.push_back(11);
    pump(xs, 1000, 0, 0);
    total++;
    if (g_d.size() != 2) begin bad++; $display("FAIL commit_count got=%0d want=2", g_d.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (!g_h[i] || g_d[i] !== g_ed[i]) begin bad++; $display("FAIL commit_value[%0d] got=%0d want=%0d", i, g_d[i], g_ed[i]); end
      end
    end
    cfg_we = 1'b1; cfg_idx = '0; cfg_en = 1'b1; cfg_neg = 1'b0; cfg_shift = 3'd2; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    xs.delete(); xs.push_back(3);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0]) begin bad++; $display("FAIL we_commit_old got_n=%0d want_n=1", g_d.size()); end
    commit();
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0]) begin bad++; $display("FAIL we_commit_new got_n=%0d want_n=1", g_d.size()); end
    // Reset while samples are in flight
    for (int k = 0; k < 3; k++) begin bus.in_valid = 1'b1; bus.in_sample = DATA_W'(20 + k); tick(); end
    bus.in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.out_valid); end
    for (int c = 0; c < 6; c++) begin tick(); if (t_of) fired++; end
    total++; if (fired != 0) begin bad++; $display("FAIL midrst_lost got=%0d want=0", fired); end
    xs.delete(); xs.push_back(9);
    pump(xs, 1000, 0, -1);
    total++; if (g_d.size() != 1 || !g_h[0] || g_d[0] !== g_ed[0]) begin bad++; $display("FAIL midrst_factor got_n=%0d want_n=1", g_d.size()); end
  endtask

  task automatic test_random();
    longint xs[$];
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_TERMS; i++)
        cfg_write(i, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
      commit();
      xs.delete();
      for (int k = 0; k < 20; k++)
        xs.push_back((r % 2 == 0) ? longint'($urandom_range(0, 600)) - 300
                                  : longint'($urandom_range(0, 65535)) - 32768);
      pump(xs, $urandom_range(0, 10), $urandom_range(0, 5), -1);
      total++;
      if (g_d.size() != 20) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=20", r, g_d.size()); end
      else begin
        for (int i = 0; i < 20; i++) begin
          total++;
          if (!g_h[i] || g_d[i] !== g_ed[i] || g_s[i] !== g_es[i])
            begin bad++; $display("FAIL rand_value[%0d.%0d] got=%0d/%b want=%0d/%b", r, i, g_d[i], g_s[i], g_ed[i], g_es[i]); end
        end
      end
    end
  endtask

  task automatic test_frac();
    longint xs[$], got[$];
    longint y;
    bit     s;
    do_reset();
    xs.push_back(5); xs.push_back(6); xs.push_back(-6);
    bus2.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus2.in_valid  = (c < 3);
      bus2.in_sample = (c < 3) ? DATA_W'(xs[c]) : '0;
      tick();
      if (bus2.out_valid) got.push_back(bus2.out_sample);
    end
    bus2.in_valid = 1'b0;
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL frac_count got=%0d want=3", got.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        ref_out(xs[i], factor_now(), 2, y, s);
        total++;
        if (got[i] !== y) begin bad++; $display("FAIL frac_value[%0d] got=%0d want=%0d", i, got[i], y); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sat_clr = 1'b0;
    cfg_we = 1'b0; cfg_en = 1'b0; cfg_neg = 1'b0; cfg_commit = 1'b0; cfg_idx = '0; cfg_shift = '0;
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_sample = '0; bus2.out_ready = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_commit();
    test_random();
    test_frac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
